// File: rtl/nonce_result_scan_if.sv
// Single-port memory bus shared with the hash block; the scanner drives it as master.
interface nonce_result_scan_if;
    logic        mem_clk;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    modport master (
        output mem_clk, mem_we, mem_addr, mem_write_data,
        input  mem_read_data
    );

    modport slave (
        input  mem_clk, mem_we, mem_addr, mem_write_data,
        output mem_read_data
    );
endinterface

// File: rtl/nonce_result_scan.sv
// Streams NUM_NONCES per-nonce h0 words from memory, tracks hits below target and the
// smallest h0, then writes a two-word summary back through the same memory port.
module nonce_result_scan #(
    parameter int NUM_NONCES = 16,
    parameter int NONCE_W    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [15:0]           result_addr,
    input  logic [15:0]           summary_addr,
    input  logic [31:0]           target,
    output logic                  done,
    output logic                  found,
    output logic [7:0]            hit_count,
    output logic [NONCE_W-1:0]    best_nonce,
    output logic [31:0]           best_hash,
    nonce_result_scan_if.master   mem
);

    localparam int CNT_W = $clog2(NUM_NONCES + 1);
    localparam logic [CNT_W-1:0] N_C  = CNT_W'(NUM_NONCES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_NONCES - 1);

    typedef enum logic [2:0] {IDLE, SCAN, WR0, WR1, DONE} state_t;

    state_t               state_q, state_d;
    logic [15:0]          ra_q, ra_d;
    logic [15:0]          sa_q, sa_d;
    logic [31:0]          tgt_q, tgt_d;
    logic [CNT_W-1:0]     iss_cnt_q, iss_cnt_d;
    logic [CNT_W-1:0]     rd_idx_q, rd_idx_d;
    // Read-in-flight tracker: bit 0 = address issued last edge, bit 1 = data lands this edge.
    logic [1:0]           vld_pipe_q, vld_pipe_d;
    logic                 mem_we_q, mem_we_d;
    logic [15:0]          mem_addr_q, mem_addr_d;
    logic [31:0]          mem_wdata_q, mem_wdata_d;
    logic                 done_q, done_d;
    logic                 found_q, found_d;
    logic [7:0]           hit_q, hit_d;
    logic [NONCE_W-1:0]   bn_q, bn_d;
    logic [31:0]          bh_q, bh_d;

    always_comb begin
        state_d     = state_q;
        ra_d        = ra_q;
        sa_d        = sa_q;
        tgt_d       = tgt_q;
        iss_cnt_d   = iss_cnt_q;
        rd_idx_d    = rd_idx_q;
        vld_pipe_d  = {vld_pipe_q[0], 1'b0};
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = done_q;
        found_d     = found_q;
        hit_d       = hit_q;
        bn_d        = bn_q;
        bh_d        = bh_q;

        case (state_q)
            IDLE, DONE: begin
                done_d = (state_q == DONE);
                if (start) begin
                    ra_d          = result_addr;
                    sa_d          = summary_addr;
                    tgt_d         = target;
                    mem_addr_d    = result_addr;
                    iss_cnt_d     = CNT_W'(1);
                    rd_idx_d      = '0;
                    vld_pipe_d[0] = 1'b1;
                    done_d        = 1'b0;
                    found_d       = 1'b0;
                    hit_d         = 8'd0;
                    bn_d          = '0;
                    bh_d          = 32'hFFFF_FFFF;
                    state_d       = SCAN;
                end
            end
            SCAN: begin
                if (iss_cnt_q < N_C) begin
                    mem_addr_d    = ra_q + 16'(iss_cnt_q);
                    iss_cnt_d     = iss_cnt_q + CNT_W'(1);
                    vld_pipe_d[0] = 1'b1;
                end
                if (vld_pipe_q[1]) begin
                    if (mem.mem_read_data < tgt_q) begin
                        hit_d   = hit_q + 8'd1;
                        found_d = 1'b1;
                    end
                    // Strict compare keeps the lower nonce on ties.
                    if (mem.mem_read_data < bh_q) begin
                        bh_d = mem.mem_read_data;
                        bn_d = NONCE_W'(rd_idx_q);
                    end
                    rd_idx_d = rd_idx_q + CNT_W'(1);
                    if (rd_idx_q == LAST) state_d = WR0;
                end
            end
            WR0: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = sa_q;
                mem_wdata_d = {found_q, 7'b0, hit_q, 8'b0, 8'(bn_q)};
                state_d     = WR1;
            end
            WR1: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = sa_q + 16'd1;
                mem_wdata_d = bh_q;
                state_d     = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ra_q        <= '0;
            sa_q        <= '0;
            tgt_q       <= '0;
            iss_cnt_q   <= '0;
            rd_idx_q    <= '0;
            vld_pipe_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            found_q     <= 1'b0;
            hit_q       <= 8'd0;
            bn_q        <= '0;
            bh_q        <= 32'hFFFF_FFFF;
        end else begin
            state_q     <= state_d;
            ra_q        <= ra_d;
            sa_q        <= sa_d;
            tgt_q       <= tgt_d;
            iss_cnt_q   <= iss_cnt_d;
            rd_idx_q    <= rd_idx_d;
            vld_pipe_q  <= vld_pipe_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            found_q     <= found_d;
            hit_q       <= hit_d;
            bn_q        <= bn_d;
            bh_q        <= bh_d;
        end
    end

    assign mem.mem_clk        = clk;
    assign mem.mem_we         = mem_we_q;
    assign mem.mem_addr       = mem_addr_q;
    assign mem.mem_write_data = mem_wdata_q;

    assign done       = done_q;
    assign found      = found_q;
    assign hit_count  = hit_q;
    assign best_nonce = bn_q;
    assign best_hash  = bh_q;

endmodule

// File: tb/tb_nonce_result_scan.sv
// Randomized bench for nonce_result_scan: a loop-based reference model feeds a scoreboard
// queue that a negedge monitor drains on every summary write and on every rising done.
module tb_nonce_result_scan;
    localparam int N = 16;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [15:0] result_addr, summary_addr;
    logic [31:0] target;
    logic        done, found;
    logic [7:0]  hit_count;
    logic [7:0]  best_nonce;
    logic [31:0] best_hash;

    nonce_result_scan_if bus ();

    nonce_result_scan #(.NUM_NONCES(N), .NONCE_W(8)) dut (
        .clk(clk), .reset(reset), .start(start),
        .result_addr(result_addr), .summary_addr(summary_addr), .target(target),
        .done(done), .found(found), .hit_count(hit_count),
        .best_nonce(best_nonce), .best_hash(best_hash), .mem(bus)
    );

    always #5 clk = ~clk;

    // Memory: address registered at edge k, data registered at k+1, consumed at k+2.
    logic [31:0] mem [65536];
    always @(posedge clk) begin
        bus.mem_read_data <= mem[bus.mem_addr];
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_write_data;
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0, failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    typedef struct {
        logic [15:0] sa;
        logic [31:0] w0, w1;
        logic        fnd;
        logic [7:0]  hits, bn;
        logic [31:0] bh;
        int          done_cyc;
    } exp_t;
    exp_t exp_q[$];

    function automatic exp_t model(input logic [15:0] ra, input logic [15:0] sa,
                                   input logic [31:0] tgt);
        exp_t e;
        logic [15:0] a;
        logic [31:0] w;
        e.sa = sa; e.hits = 0; e.bn = 0; e.bh = 32'hFFFF_FFFF; e.done_cyc = 0;
        for (int i = 0; i < N; i++) begin
            a = ra + 16'(i);
            w = mem[a];
            if (w < tgt) e.hits++;
            if (w < e.bh) begin e.bh = w; e.bn = 8'(i); end
        end
        e.fnd = (e.hits != 0);
        e.w0  = {e.fnd, 7'b0, e.hits, 8'b0, e.bn};
        e.w1  = e.bh;
        return e;
    endfunction

    // Monitor: checks each write against the queued expectation and the result on done rising.
    int   we_cnt = 0;
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            we_cnt = 0;
            done_prev = 1'b0;
        end else begin
            if (bus.mem_we) begin
                if (exp_q.size() == 0) chk("unexpected_write", 32'(bus.mem_we), 32'd0);
                else begin
                    chk("wr_addr", 32'(bus.mem_addr),
                        32'(exp_q[0].sa + ((we_cnt == 0) ? 16'd0 : 16'd1)));
                    chk("wr_data", bus.mem_write_data, (we_cnt == 0) ? exp_q[0].w0 : exp_q[0].w1);
                end
                we_cnt++;
            end
            if (done && !done_prev) begin
                if (exp_q.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
                    chk("found", 32'(found), 32'(e.fnd));
                    chk("hit_count", 32'(hit_count), 32'(e.hits));
                    chk("best_nonce", 32'(best_nonce), 32'(e.bn));
                    chk("best_hash", best_hash, e.bh);
                    chk("we_cycles", 32'(we_cnt), 32'd2);
                    chk("mem_summary0", mem[e.sa], e.w0);
                    chk("mem_summary1", mem[16'(e.sa + 16'd1)], e.w1);
                end
                we_cnt = 0;
            end
            done_prev = done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // One full scan; pulse_at >= 0 pulses a stray start during SCAN.
    task automatic run(input logic [15:0] ra, input logic [15:0] sa, input logic [31:0] tgt,
                       input int pulse_at);
        exp_t e;
        int   s;
        logic [15:0] a;
        e = model(ra, sa, tgt);
        result_addr = ra; summary_addr = sa; target = tgt; start = 1'b1;
        tick();
        start = 1'b0;
        s = cyc;
        e.done_cyc = s + N + 4;
        exp_q.push_back(e);
        result_addr = 16'($urandom); summary_addr = 16'($urandom); target = $urandom;
        chk("done_drop", 32'(done), 32'd0);
        for (int j = 0; j < N; j++) begin
            a = ra + 16'(j);
            chk("rd_addr", 32'(bus.mem_addr), 32'(a));
            chk("we_in_scan", 32'(bus.mem_we), 32'd0);
            start = (j == pulse_at);
            tick();
            start = 1'b0;
        end
        for (int k = 0; k < 20 && !done; k++) tick();
        chk("done_timeout", 32'(done), 32'd1);
        tick();
    endtask

    task automatic fill_rand(input logic [15:0] ra, input int shift);
        logic [15:0] a;
        for (int i = 0; i < N; i++) begin
            a = ra + 16'(i);
            mem[a] = $urandom >> shift;
        end
    endtask

    initial begin
        logic [15:0] a, ra;
        int s;
        reset = 1'b1; start = 1'b0;
        result_addr = '0; summary_addr = '0; target = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
        tick(); tick(); tick();
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_we", 32'(bus.mem_we), 32'd0);
        chk("rst_found", 32'(found), 32'd0);
        chk("rst_hits", 32'(hit_count), 32'd0);
        chk("rst_bn", 32'(best_nonce), 32'd0);
        chk("rst_bh", best_hash, 32'hFFFF_FFFF);
        chk("rst_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_wdata", bus.mem_write_data, 32'd0);
        reset = 1'b0;
        tick();

        // Descending words; 11 of them fall below the target.
        for (int i = 0; i < N; i++) mem[16'h100 + i] = 32'h8000_0000 - 32'h1000 * i;
        run(16'h0100, 16'h0200, 32'h7FFF_C000, -1);
        chk("tp1_hits", 32'(hit_count), 32'd11);
        chk("tp1_bn", 32'(best_nonce), 32'd15);
        chk("tp1_bh", best_hash, 32'h7FFF_1000);
        chk("tp1_sum0", mem[16'h200], 32'h800B_000F);
        chk("tp1_sum1", mem[16'h201], 32'h7FFF_1000);

        // All-ones words, target 0: no hit and best stays at its initial value.
        for (int i = 0; i < N; i++) mem[16'h400 + i] = 32'hFFFF_FFFF;
        run(16'h0400, 16'h0500, 32'h0, -1);
        chk("ones_found", 32'(found), 32'd0);
        chk("ones_bn", 32'(best_nonce), 32'd0);
        chk("ones_sum0", mem[16'h500], 32'h0);

        // Tie between nonces 3 and 9.
        for (int i = 0; i < N; i++) mem[16'h600 + i] = $urandom_range(32'hFFFF_FFFF, 32'h100);
        mem[16'h603] = 32'h42; mem[16'h609] = 32'h42;
        run(16'h0600, 16'h0700, 32'h100, 5);
        chk("tie_bn", 32'(best_nonce), 32'd3);
        chk("tie_hits", 32'(hit_count), 32'd2);

        // Max target with some all-ones words mixed in.
        fill_rand(16'h0800, 0);
        mem[16'h802] = 32'hFFFF_FFFF; mem[16'h80C] = 32'hFFFF_FFFF;
        run(16'h0800, 16'h0900, 32'hFFFF_FFFF, -1);
        chk("maxtgt_hits", 32'(hit_count), 32'd14);

        // Reset lands on the 7th edge of a scan.
        fill_rand(16'h0A00, 4);
        result_addr = 16'h0A00; summary_addr = 16'h0B00; target = 32'h0800_0000; start = 1'b1;
        tick();
        start = 1'b0;
        s = cyc;
        while (cyc < s + 6) tick();
        reset = 1'b1;
        tick();
        chk("mid_rst_we", 32'(bus.mem_we), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_hits", 32'(hit_count), 32'd0);
        chk("mid_rst_bh", best_hash, 32'hFFFF_FFFF);
        reset = 1'b0;
        tick();
        chk("idle_we", 32'(bus.mem_we), 32'd0);
        run(16'h0A00, 16'h0B00, 32'h0100_0000, -1);

        // Address wrap at the top of the 16-bit space, with a stray start mid-scan.
        for (int i = 0; i < N; i++) begin
            a = 16'hFFF8 + 16'(i);
            mem[a] = $urandom >> (i % 3);
        end
        run(16'hFFF8, 16'h3000, 32'h4000_0000, 5);

        // Back-to-back random runs, each started from DONE.
        for (int r = 0; r < 6; r++) begin
            ra = 16'h1000 + 16'($urandom_range(0, 16'h6000));
            fill_rand(ra, (r % 2) * 6);
            run(ra, ra + 16'h0800, $urandom >> ($urandom_range(0, 3) * 2),
                (r % 3 == 0) ? $urandom_range(0, N - 1) : -1);
        end

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/nonce_result_scan.md
Name: nonce_result_scan

Overview:
- Reader for the per-nonce result words that the bitcoin hash block writes to memory: NUM_NONCES consecutive 32-bit h0 words starting at result_addr, word index = nonce.
- Streams the words back over the same single-port memory interface and compares each word, unsigned, against a difficulty target.
- Tracks the best (smallest) h0, its nonce and the hit count, then writes a two-word summary to summary_addr.
- Runs after the hash block asserts done; shares its memory.

Parameters:
NUM_NONCES, 16, number of result words to scan; legal range 1..255
NONCE_W, 8, width of nonce index and best_nonce output

Ports:
clk  in  1  system clock; also drives mem_clk
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; sampled only in IDLE or DONE
result_addr  in  16  address of word for nonce 0
summary_addr  in  16  address of the 2-word summary
target  in  32  unsigned difficulty target; a word is a hit when h0 < target
done  out  1  high when scan and summary write are complete
found  out  1  at least one hit
hit_count  out  8  number of hits
best_nonce  out  NONCE_W  nonce of the smallest h0
best_hash  out  32  smallest h0 seen
mem_clk  out  1  equals clk
mem_we  out  1  memory write enable
mem_addr  out  16  memory address
mem_write_data  out  32  memory write data
mem_read_data  in  32  memory read data

Behaviour:
- One clock, clk. Reset is synchronous and active-high.
- Reset, or any cycle with reset=1, including mid-scan:
  - State goes to IDLE.
  - done, mem_we, found, hit_count, best_nonce, mem_addr and mem_write_data all go to 0.
  - best_hash goes to 32'hFFFFFFFF.
- Memory timing: a read is issued by registering mem_addr at edge k; its data is sampled at edge k+2. One read is issued per cycle, fully pipelined.
- All outputs are registered.
- States:
  - IDLE: on start, latch result_addr, summary_addr and target. Set mem_addr=result_addr, issue counter=1, clear accumulators, done=0. Go to SCAN.
  - SCAN: each cycle, while issue counter < NUM_NONCES, mem_addr=result_addr+issue counter and the counter increments. From the second SCAN edge on, sample mem_read_data as word rd_idx, then rd_idx++. After sampling word NUM_NONCES-1, go to WR0.
  - WR0: mem_we=1, mem_addr=summary_addr, mem_write_data={found', 7'b0, hit_count', 8'b0, best_nonce' zero-extended to 8 bits}. Primed values (found', hit_count', best_nonce') include the final word. Go to WR1.
  - WR1: mem_we=1, mem_addr=summary_addr+1, mem_write_data=best_hash'. Go to DONE.
  - DONE: mem_we=0, done=1, held until reset or start. A start here behaves as in IDLE; done drops on that edge.
- Per sampled word w at index i:
  - If w < target (unsigned): hit_count++ and found=1.
  - If w < best_hash (strict): best_hash=w, best_nonce=i. Ties keep the lower nonce.
  - If every word is 32'hFFFFFFFF, best_nonce=0 and best_hash=32'hFFFFFFFF.
- target=0 never hits. target=32'hFFFFFFFF hits every word except FFFFFFFF.
- Address arithmetic is 16-bit and wraps modulo 2^16, e.g. result_addr=16'hFFFF reads FFFF, 0000, ...
- start while in SCAN, WR0 or WR1 is ignored. result_addr, summary_addr and target may change after the start edge without effect.
- mem_we=0 in every state other than WR0 and WR1.
- Latency: start sampled at edge 0 → WR0 write at edge NUM_NONCES+2, WR1 write at NUM_NONCES+3, done=1 at NUM_NONCES+4.

Test Plan:
- Memory 0x100..0x10F preloaded with h0 = 0x8000_0000 - 0x1000*i, target=0x7FFF_C000, NUM_NONCES=16, start → hit_count=11, found=1, best_nonce=15, best_hash=0x7FFF_1000; summary at 0x200 = 0x800B_000F then 0x7FFF_1000; done at edge 20.
- All words 0xFFFFFFFF, target=0 → found=0, hit_count=0, best_nonce=0, best_hash=0xFFFFFFFF; summary word0=0x0000_0000.
- Tie: words 3 and 9 both 0x0000_0042, all others larger → best_nonce=3.
- Reset asserted at edge 7 of a scan → next edge: IDLE, mem_we=0, done=0; a new start completes normally, with no stale hits.
- result_addr=0xFFF8 → reads wrap to 0x0000..0x0007; second start pulsed during SCAN is ignored; start in DONE reruns and done drops for exactly NUM_NONCES+4 cycles.
- Check mem_addr sequence and the two-cycle read latency cycle by cycle; mem_we high for exactly 2 cycles per run.
